// File: rtl/frog_pkg.sv
// Shared definitions for the frog game controller: state encoding, screen
// geometry, spawn point, per-lane car dividers and signal widths.
package frog_pkg;

  localparam int unsigned H_DISPLAY     = 640;
  localparam int unsigned V_DISPLAY     = 480;
  localparam int unsigned PLAYER_WIDTH  = 32;
  localparam int unsigned PLAYER_HEIGHT = 32;

  // Largest legal top-left coordinates keeping the player fully on screen.
  localparam int unsigned X_MAX = H_DISPLAY - PLAYER_WIDTH;
  localparam int unsigned Y_MAX = V_DISPLAY - PLAYER_HEIGHT;

  localparam int unsigned SPAWN_X = 304;
  localparam int unsigned SPAWN_Y = 448;

  localparam int unsigned POS_W     = 10;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LIVES_W   = 2;
  localparam int unsigned LEVEL_W   = 3;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned TIME_W    = 11;
  localparam int unsigned DIV_W     = 4;
  localparam int unsigned TIME_LOAD = 1800;

  typedef enum logic [STATE_W-1:0] {
    ST_ATTRACT  = 3'd0,
    ST_PLAY     = 3'd1,
    ST_HIT      = 3'd2,
    ST_LEVEL_UP = 3'd3,
    ST_OVER     = 3'd4
  } state_t;

  // Base frame divider per lane; higher levels shorten the period.
  localparam logic [DIV_W-1:0] LANE_DIV [LANES] = '{4'd4, 4'd6, 4'd3, 4'd5};

  // Lane period at a given level: max(1, div - level).
  function automatic logic [DIV_W-1:0] lane_period(input logic [DIV_W-1:0] div,
                                                   input logic [LEVEL_W-1:0] level);
    logic [DIV_W-1:0] lvl;
    lvl = DIV_W'(level);
    return (div > lvl + DIV_W'(1)) ? div - lvl : DIV_W'(1);
  endfunction

endpackage

// File: rtl/frog_game_ctrl_if.sv
// Frog game controller bus: frame tick, switches and collision flag in;
// player position, car strobes, lives/level/state and timer out.
//   slave  : controller side (inputs from renderer/board, outputs to renderer)
//   master : environment side (drives inputs, observes outputs)
interface frog_game_ctrl_if;
  import frog_pkg::*;

  logic                 FRAME_TICK;
  logic                 SW1;
  logic                 SW2;
  logic                 SW3;
  logic                 SW4;
  logic                 COLLIDE;
  logic [POS_W-1:0]     PLAYER_X;
  logic [POS_W-1:0]     PLAYER_Y;
  logic [LANES-1:0]     CAR_STEP;
  logic [LIVES_W-1:0]   LIVES;
  logic [LEVEL_W-1:0]   LEVEL;
  logic [STATE_W-1:0]   STATE;
  logic [TIME_W-1:0]    TIME_LEFT;

  modport slave (
    input  FRAME_TICK, SW1, SW2, SW3, SW4, COLLIDE,
    output PLAYER_X, PLAYER_Y, CAR_STEP, LIVES, LEVEL, STATE, TIME_LEFT
  );

  modport master (
    output FRAME_TICK, SW1, SW2, SW3, SW4, COLLIDE,
    input  PLAYER_X, PLAYER_Y, CAR_STEP, LIVES, LEVEL, STATE, TIME_LEFT
  );

endinterface

// File: rtl/frog_lane_div.sv
// One car lane frame divider. Counts FRAME_TICKs while running and emits a
// one-cycle step strobe in the cycle after the tick on which it expires.
//   clk, rst_n  : clock, async active-low reset
//   frame_tick  : start-of-vblank pulse
//   run         : advance the divider on this tick
//   reload      : load the period on this tick (entry to play)
//   period      : current reload period (>= 1)
//   step        : registered advance strobe
module frog_lane_div
  import frog_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             run,
  input  logic             reload,
  input  logic [DIV_W-1:0] period,
  output logic             step
);

  logic [DIV_W-1:0] cnt_q;

  // Divider: count holds unless running; strobe lasts a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      if (frame_tick) begin
        if (reload) begin
          cnt_q <= period;
        end else if (run) begin
          if (cnt_q <= DIV_W'(1)) begin
            step  <= 1'b1;
            cnt_q <= period;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/frog_game_ctrl.sv
// Frog game controller: game FSM, player movement with clamping and move
// hold-off, collision latch, lives/level bookkeeping and per-lane car dividers.
// All state changes happen on FRAME_TICK cycles.
//   CLK, RST_N : clock, async active-low reset
//   bus        : frog_game_ctrl_if.slave (FRAME_TICK, SW1..SW4, COLLIDE in;
//                PLAYER_X/Y, CAR_STEP, LIVES, LEVEL, STATE, TIME_LEFT out)
// Optional feature macro: FROG_TIMER_EN (per-life frame timer; timeout acts
// as a collision). Without it TIME_LEFT is tied to 0.
module frog_game_ctrl
  import frog_pkg::*;
#(
  parameter int unsigned STEP        = 32,
  parameter int unsigned MOVE_HOLD   = 8,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned HIT_FRAMES  = 60,
  parameter int unsigned LVL_FRAMES  = 30
) (
  input logic               CLK,
  input logic               RST_N,
  frog_game_ctrl_if.slave   bus
);

  localparam int unsigned MV_W   = (MOVE_HOLD > 1) ? $clog2(MOVE_HOLD) : 1;
  localparam int unsigned PH_MAX = (HIT_FRAMES > LVL_FRAMES) ? HIT_FRAMES : LVL_FRAMES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [POS_W-1:0] STEP_V    = POS_W'(STEP);
  localparam logic [POS_W-1:0] X_MAX_V   = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_MAX_V   = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] SPAWN_X_V = POS_W'(SPAWN_X);
  localparam logic [POS_W-1:0] SPAWN_Y_V = POS_W'(SPAWN_Y);

  state_t             state_q, state_d;
  logic [POS_W-1:0]   px_q, px_d, py_q, py_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [MV_W-1:0]    mv_q, mv_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic               hit_q, hit_d;
  logic               rel_q, rel_d;
`ifdef FROG_TIMER_EN
  logic [TIME_W-1:0]  time_q, time_d;
`endif

  logic               sw_any, hit_now, timeout, moved, enter_play;
  logic               lane_run, lane_reload;
  logic [LANES-1:0]   car_step;

  assign sw_any = bus.SW1 | bus.SW2 | bus.SW3 | bus.SW4;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_ATTRACT;
      px_q    <= SPAWN_X_V;
      py_q    <= SPAWN_Y_V;
      lives_q <= '0;
      level_q <= '0;
      mv_q    <= '0;
      ph_q    <= '0;
      hit_q   <= 1'b0;
      rel_q   <= 1'b0;
`ifdef FROG_TIMER_EN
      time_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      lives_q <= lives_d;
      level_q <= level_d;
      mv_q    <= mv_d;
      ph_q    <= ph_d;
      hit_q   <= hit_d;
      rel_q   <= rel_d;
`ifdef FROG_TIMER_EN
      time_q  <= time_d;
`endif
    end
  end

  // Next-state, movement and bookkeeping.
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    lives_d    = lives_q;
    level_d    = level_q;
    mv_d       = mv_q;
    ph_d       = ph_q;
    hit_d      = hit_q;
    rel_d      = rel_q;
    moved      = 1'b0;
    enter_play = 1'b0;
`ifdef FROG_TIMER_EN
    time_d     = time_q;
    timeout    = (state_q == ST_PLAY) && (time_q == TIME_W'(1));
`else
    timeout    = 1'b0;
`endif
    // A collision on the tick cycle itself still counts for that tick.
    hit_now = hit_q | ((state_q == ST_PLAY) & bus.COLLIDE);

    if (!bus.FRAME_TICK) begin
      hit_d = hit_now;
    end else begin
      hit_d = 1'b0;
      case (state_q)
        ST_ATTRACT: begin
          if (sw_any) begin
            state_d    = ST_PLAY;
            lives_d    = LIVES_W'(START_LIVES);
            level_d    = '0;
            enter_play = 1'b1;
          end
        end
        ST_PLAY: begin
`ifdef FROG_TIMER_EN
          time_d = (time_q != '0) ? time_q - TIME_W'(1) : '0;
`endif
          // Collision outranks reaching the top and suppresses the move.
          if (hit_now || timeout) begin
            state_d = ST_HIT;
            lives_d = lives_q - LIVES_W'(1);
            ph_d    = PH_W'(HIT_FRAMES - 1);
          end else if (py_q == '0) begin
            state_d = ST_LEVEL_UP;
            ph_d    = PH_W'(LVL_FRAMES - 1);
          end else if (mv_q != '0) begin
            mv_d = mv_q - MV_W'(1);
          end else if (sw_any) begin
            // Highest-priority switch only; a clamped move leaves move_cnt at 0.
            if (bus.SW1) begin
              if (py_q >= STEP_V) begin
                py_d  = py_q - STEP_V;
                moved = 1'b1;
              end
            end else if (bus.SW2) begin
              if ({1'b0, py_q} + {1'b0, STEP_V} <= {1'b0, Y_MAX_V}) begin
                py_d  = py_q + STEP_V;
                moved = 1'b1;
              end
            end else if (bus.SW3) begin
              if (px_q >= STEP_V) begin
                px_d  = px_q - STEP_V;
                moved = 1'b1;
              end
            end else begin
              if ({1'b0, px_q} + {1'b0, STEP_V} <= {1'b0, X_MAX_V}) begin
                px_d  = px_q + STEP_V;
                moved = 1'b1;
              end
            end
            if (moved) mv_d = MV_W'(MOVE_HOLD - 1);
          end
        end
        ST_HIT: begin
          if (ph_q != '0) begin
            ph_d = ph_q - PH_W'(1);
          end else if (lives_q == '0) begin
            state_d = ST_OVER;
            rel_d   = 1'b0;
          end else begin
            state_d    = ST_PLAY;
            enter_play = 1'b1;
          end
        end
        ST_LEVEL_UP: begin
          if (ph_q != '0) begin
            ph_d = ph_q - PH_W'(1);
          end else begin
            if (level_q != '1) level_d = level_q + LEVEL_W'(1);
            state_d    = ST_PLAY;
            enter_play = 1'b1;
          end
        end
        ST_OVER: begin
          // Require an all-released tick before a press returns to attract.
          if (!rel_q) begin
            if (!sw_any) rel_d = 1'b1;
          end else if (sw_any) begin
            state_d = ST_ATTRACT;
            rel_d   = 1'b0;
          end
        end
        default: state_d = ST_ATTRACT;
      endcase

      if (enter_play) begin
        px_d = SPAWN_X_V;
        py_d = SPAWN_Y_V;
        mv_d = '0;
`ifdef FROG_TIMER_EN
        time_d = TIME_W'(TIME_LOAD);
`endif
      end
    end
  end

  // Lanes advance only on ticks that stay in play; reload uses the new level.
  assign lane_run    = bus.FRAME_TICK && (state_q == ST_PLAY) && (state_d == ST_PLAY);
  assign lane_reload = bus.FRAME_TICK && enter_play;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DIV_W-1:0] period;
    assign period = lane_period(LANE_DIV[k], level_d);

    frog_lane_div u_div (
      .clk        (CLK),
      .rst_n      (RST_N),
      .frame_tick (bus.FRAME_TICK),
      .run        (lane_run),
      .reload     (lane_reload),
      .period     (period),
      .step       (car_step[k])
    );
  end

  assign bus.PLAYER_X = px_q;
  assign bus.PLAYER_Y = py_q;
  assign bus.CAR_STEP = car_step;
  assign bus.LIVES    = lives_q;
  assign bus.LEVEL    = level_q;
  assign bus.STATE    = state_q;
`ifdef FROG_TIMER_EN
  assign bus.TIME_LEFT = time_q;
`else
  assign bus.TIME_LEFT = '0;
`endif

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl: reset, attract entry, held movement with
// hold-off, lane strobes, hits, clamping, level-up and game-over handling.
module tb_frog_game_ctrl;
  import frog_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] step_seen;

  // Expected CAR_STEP per play tick at level 0 (periods 4,6,3,5) and level 1 (3,5,2,4).
  logic [3:0] steps_l0 [12] = '{4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b1000, 4'b0110,
                                4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b0000, 4'b0111};
  logic [3:0] steps_l1 [6]  = '{4'b0000, 4'b0100, 4'b0001, 4'b1100, 4'b0010, 4'b0101};

  frog_game_ctrl_if bus ();

  frog_game_ctrl dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame: tick for a cycle, capture the strobe cycle after it, idle.
  task automatic frame();
    @(negedge clk);
    bus.FRAME_TICK = 1'b1;
    @(negedge clk);
    bus.FRAME_TICK = 1'b0;
    step_seen = bus.CAR_STEP;
    repeat (4) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic collide_pulse();
    @(negedge clk);
    bus.COLLIDE = 1'b1;
    @(negedge clk);
    bus.COLLIDE = 1'b0;
  endtask

  // s = {SW4, SW3, SW2, SW1}
  task automatic set_sw(input logic [3:0] s);
    bus.SW1 = s[0];
    bus.SW2 = s[1];
    bus.SW3 = s[2];
    bus.SW4 = s[3];
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.FRAME_TICK = 1'b0;
    bus.COLLIDE    = 1'b0;
    set_sw(4'b0000);
    repeat (3) @(negedge clk);

    check("rst_state", 32'(bus.STATE), 32'(ST_ATTRACT));
    check("rst_x", 32'(bus.PLAYER_X), 32'd304);
    check("rst_y", 32'(bus.PLAYER_Y), 32'd448);
    check("rst_car", 32'(bus.CAR_STEP), 32'd0);
    check("rst_lives", 32'(bus.LIVES), 32'd0);
    check("rst_level", 32'(bus.LEVEL), 32'd0);
    check("rst_time", 32'(bus.TIME_LEFT), 32'd0);

    // Tick while held in reset changes nothing.
    set_sw(4'b0001);
    frame();
    check("rst_tick_state", 32'(bus.STATE), 32'(ST_ATTRACT));

    // Mid-frame release: nothing moves until the next tick.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rel_no_change", 32'(bus.STATE), 32'(ST_ATTRACT));
    check("rel_lives", 32'(bus.LIVES), 32'd0);

    frame();
    check("start_state", 32'(bus.STATE), 32'(ST_PLAY));
    check("start_lives", 32'(bus.LIVES), 32'd3);
    check("start_level", 32'(bus.LEVEL), 32'd0);
    check("start_x", 32'(bus.PLAYER_X), 32'd304);
    check("start_y", 32'(bus.PLAYER_Y), 32'd448);
    check("start_car", 32'(step_seen), 32'd0);
`ifdef FROG_TIMER_EN
    check("start_time", 32'(bus.TIME_LEFT), 32'd1800);
`else
    check("start_time", 32'(bus.TIME_LEFT), 32'd0);
`endif

    // SW1 held: moves on play ticks 1, 9, 17.
    for (int k = 1; k <= 20; k++) begin
      frame();
      check($sformatf("hold_y_%0d", k), 32'(bus.PLAYER_Y),
            (k < 9) ? 32'd416 : (k < 17) ? 32'd384 : 32'd352);
      if (k <= 12) check($sformatf("car_l0_%0d", k), 32'(step_seen), 32'(steps_l0[k-1]));
    end
    check("hold_x", 32'(bus.PLAYER_X), 32'd304);
    check("hold_state", 32'(bus.STATE), 32'(ST_PLAY));
    set_sw(4'b0000);

    // First hit.
    collide_pulse();
    frame();
    check("hit1_state", 32'(bus.STATE), 32'(ST_HIT));
    check("hit1_lives", 32'(bus.LIVES), 32'd2);
    check("hit1_y", 32'(bus.PLAYER_Y), 32'd352);
    check("hit1_car", 32'(step_seen), 32'd0);
    frames(59);
    check("hit1_hold", 32'(bus.STATE), 32'(ST_HIT));
    frame();
    check("respawn_state", 32'(bus.STATE), 32'(ST_PLAY));
    check("respawn_x", 32'(bus.PLAYER_X), 32'd304);
    check("respawn_y", 32'(bus.PLAYER_Y), 32'd448);
    frame();
    check("latch_cleared", 32'(bus.STATE), 32'(ST_PLAY));

    // Clamped down press does not start the hold-off; left moves at once.
    set_sw(4'b0010);
    frame();
    check("clamp_down_y", 32'(bus.PLAYER_Y), 32'd448);
    set_sw(4'b0100);
    frame();
    check("left_after_clamp_x", 32'(bus.PLAYER_X), 32'd272);
    set_sw(4'b0000);
    frames(7);
    set_sw(4'b1001);
    frame();
    check("prio_x", 32'(bus.PLAYER_X), 32'd272);
    check("prio_y", 32'(bus.PLAYER_Y), 32'd416);

    // Climb to Y=32, then move+collide in the same frame: hit wins.
    set_sw(4'b0001);
    frames(96);
    set_sw(4'b0000);
    check("climb_y", 32'(bus.PLAYER_Y), 32'd32);
    frames(7);
    set_sw(4'b0001);
    collide_pulse();
    frame();
    set_sw(4'b0000);
    check("hit2_state", 32'(bus.STATE), 32'(ST_HIT));
    check("hit2_lives", 32'(bus.LIVES), 32'd1);
    check("hit2_y", 32'(bus.PLAYER_Y), 32'd32);
    frames(60);
    check("hit2_back", 32'(bus.STATE), 32'(ST_PLAY));

    // Climb to the top and level up.
    set_sw(4'b0001);
    frames(105);
    set_sw(4'b0000);
    check("top_y", 32'(bus.PLAYER_Y), 32'd0);
    check("top_state", 32'(bus.STATE), 32'(ST_PLAY));
    frame();
    check("lvl_state", 32'(bus.STATE), 32'(ST_LEVEL_UP));
    check("lvl_level0", 32'(bus.LEVEL), 32'd0);
    frames(29);
    check("lvl_hold", 32'(bus.STATE), 32'(ST_LEVEL_UP));
    frame();
    check("lvl_done_state", 32'(bus.STATE), 32'(ST_PLAY));
    check("lvl_done_level", 32'(bus.LEVEL), 32'd1);
    check("lvl_done_y", 32'(bus.PLAYER_Y), 32'd448);
    for (int k = 1; k <= 6; k++) begin
      frame();
      check($sformatf("car_l1_%0d", k), 32'(step_seen), 32'(steps_l1[k-1]));
    end

    // Third hit ends the game.
    collide_pulse();
    frame();
    check("hit3_state", 32'(bus.STATE), 32'(ST_HIT));
    check("hit3_lives", 32'(bus.LIVES), 32'd0);
    frames(59);
    check("hit3_hold", 32'(bus.STATE), 32'(ST_HIT));
    frame();
    check("over_state", 32'(bus.STATE), 32'(ST_OVER));

    // Game over needs a released tick before a press counts.
    set_sw(4'b0001);
    frame();
    check("over_held", 32'(bus.STATE), 32'(ST_OVER));
    set_sw(4'b0000);
    frame();
    check("over_released", 32'(bus.STATE), 32'(ST_OVER));
    set_sw(4'b0010);
    frame();
    check("over_to_attract", 32'(bus.STATE), 32'(ST_ATTRACT));
    set_sw(4'b0000);
    frame();
    check("attract_idle", 32'(bus.STATE), 32'(ST_ATTRACT));
`ifndef FROG_TIMER_EN
    check("time_zero", 32'(bus.TIME_LEFT), 32'd0);
`endif

    // Restart, then asynchronous reset mid-frame.
    set_sw(4'b0001);
    frame();
    set_sw(4'b0000);
    check("restart_state", 32'(bus.STATE), 32'(ST_PLAY));
    check("restart_lives", 32'(bus.LIVES), 32'd3);
    check("restart_level", 32'(bus.LEVEL), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", 32'(bus.STATE), 32'(ST_ATTRACT));
    check("async_lives", 32'(bus.LIVES), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
